// File: rtl/resp_arb_pkg.sv
// Shared types for the UART response arbiter: FSM state encoding,
// source ids and the round-robin/lock grant decision.
package resp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        ACK  = 2'd3
    } arb_state_t;

    localparam logic SRC_CC  = 1'b0;
    localparam logic SRC_RAM = 1'b1;

    // RAM wins when it is the only requester, when CC had the last turn,
    // or when a locked dump already owns the channel. A lock without a
    // pending RAM byte never blocks CC.
    function automatic logic pick_ram(
        input logic cc_req,
        input logic ram_req,
        input logic ram_lock,
        input logic last_ram
    );
        return ram_req & (~cc_req | ~last_ram | ram_lock);
    endfunction

endpackage

// File: rtl/resp_tmo_cnt.sv
// Saturating timeout counter with synchronous clear and enable.
// Ports: clk, rst (async high), clr, en, tc_val -> tc (cnt == tc_val).
module resp_tmo_cnt #(
    parameter int TMO_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [TMO_W-1:0] tc_val,
    output logic             tc
);

    logic [TMO_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + TMO_W'(1);
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/resp_tx_arbiter.sv
// Arbitrates the single UART response channel between the CC response
// path and the RAM trace dump: round-robin, dump lock, stuck-UART timeout.
// Ports: clk, rst; cc_req/cc_data/cc_ack; ram_req/ram_data/ram_lock/ram_ack;
//   resp_data/send_resp/resp_sent to UART; busy, grant_ram, tmo_err, clr_err.
module resp_tx_arbiter
    import resp_arb_pkg::*;
#(
    parameter int TMO_W      = 20,
    parameter int TMO_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cc_req,
    input  logic [7:0] cc_data,
    output logic       cc_ack,
    input  logic       ram_req,
    input  logic [7:0] ram_data,
    input  logic       ram_lock,
    output logic       ram_ack,
    output logic [7:0] resp_data,
    output logic       send_resp,
    input  logic       resp_sent,
    output logic       busy,
    output logic       grant_ram,
    output logic       tmo_err,
    input  logic       clr_err
);

    localparam logic [TMO_W-1:0] TC_VAL = TMO_W'(TMO_CYCLES - 1);

    arb_state_t state;
    logic       win_ram;
    logic       tc;
    logic       tmo_hit;

    assign win_ram = pick_ram(cc_req, ram_req, ram_lock, grant_ram);
    assign tmo_hit = (TMO_CYCLES != 0) && tc;

    resp_tmo_cnt #(
        .TMO_W (TMO_W)
    ) u_tmo (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == LOAD),
        .en     ((state == WAIT) && !resp_sent),
        .tc_val (TC_VAL),
        .tc     (tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            resp_data <= 8'h00;
            send_resp <= 1'b0;
            cc_ack    <= 1'b0;
            ram_ack   <= 1'b0;
            busy      <= 1'b0;
            grant_ram <= SRC_RAM;
            tmo_err   <= 1'b0;
        end else begin
            send_resp <= 1'b0;
            cc_ack    <= 1'b0;
            ram_ack   <= 1'b0;
            // A timeout in WAIT below overrides this clear.
            if (clr_err) tmo_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cc_req || ram_req) begin
                        grant_ram <= win_ram;
                        resp_data <= win_ram ? ram_data : cc_data;
                        send_resp <= 1'b1;
                        busy      <= 1'b1;
                        state     <= LOAD;
                    end
                end
                LOAD: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (resp_sent || tmo_hit) begin
                        if (!resp_sent) tmo_err <= 1'b1;
                        cc_ack  <= ~grant_ram;
                        ram_ack <= grant_ram;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
